// File: rtl/text_draw_controller_pkg.sv
// Shared constants, glyph codes, pixel index helpers and state encoding
// for the text draw controller and its cursor.
package text_draw_controller_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ORIGIN_X = 2;
  localparam int ORIGIN_Y = 2;
  localparam int PITCH_X  = 5;
  localparam int PITCH_Y  = 6;
  localparam int GLYPH_SZ = 4;

  localparam logic [2:0] FG = 3'b111;
  localparam logic [2:0] BG = 3'b000;

  localparam logic [4:0] CODE_SPACE = 5'd0;
  localparam logic [4:0] CODE_A     = 5'd1;
  localparam logic [4:0] CODE_Z     = 5'd26;

  localparam logic [3:0] IDX_LAST = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_DRAW   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Glyph pixel index: [3:2] selects the row, [1:0] the column.
  function automatic logic [1:0] idx_row(input logic [3:0] idx);
    return idx[3:2];
  endfunction

  function automatic logic [1:0] idx_col(input logic [3:0] idx);
    return idx[1:0];
  endfunction

endpackage

// File: rtl/text_draw_controller_text_cursor.sv
// Text cursor: advances one glyph cell with line and screen wrap, or homes
// to the origin. Arithmetic is one bit wider than the outputs need.
module text_cursor
  import text_draw_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_advance,
  input  logic       i_home,
  output logic [8:0] o_cursor_x,
  output logic [7:0] o_cursor_y
);

  logic [8:0] r_x;
  logic [7:0] r_y;
  logic [8:0] w_step_x;
  logic [7:0] w_line_y;
  logic       w_wrap_line;
  logic       w_wrap_screen;

  assign w_step_x      = r_x + 9'(PITCH_X);
  assign w_wrap_line   = (w_step_x + 9'(GLYPH_SZ)) > 9'(SCREEN_W);
  assign w_line_y      = r_y + 8'(PITCH_Y);
  assign w_wrap_screen = (w_line_y + 8'(GLYPH_SZ)) > 8'(SCREEN_H);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x <= 9'(ORIGIN_X);
      r_y <= 8'(ORIGIN_Y);
    end else if (i_home) begin
      r_x <= 9'(ORIGIN_X);
      r_y <= 8'(ORIGIN_Y);
    end else if (i_advance) begin
      if (w_wrap_line) begin
        r_x <= 9'(ORIGIN_X);
        r_y <= w_wrap_screen ? 8'(ORIGIN_Y) : w_line_y;
      end else begin
        r_x <= w_step_x;
      end
    end
  end

  assign o_cursor_x = r_x;
  assign o_cursor_y = r_y;

endmodule

// File: rtl/text_draw_controller.sv
// Text draw controller: accepts letter codes, walks the glyph ROM 16 pixels
// per character into the framebuffer, and performs full-screen clears.
module text_draw_controller
  import text_draw_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic [4:0] char_code,
  output logic       char_ready,
  input  logic       clear_req,
  output logic [4:0] rom_char,
  output logic [3:0] rom_index,
  input  logic       glyph_bit,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  state_t     r_state, w_next_state;
  logic [3:0] r_idx;
  logic [4:0] r_code;
  logic [8:0] r_sweep_x;
  logic [7:0] r_sweep_y;
  logic       r_clear_op;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;

  logic       w_char_ready;
  logic       w_accept;
  logic       w_plot;
  logic       w_done;
  logic       w_advance;
  logic       w_home;
  logic [3:0] w_rom_index;
  logic [7:0] w_x;
  logic [6:0] w_y;
  logic [2:0] w_colour;
  logic [8:0] w_cursor_x;
  logic [7:0] w_cursor_y;
  logic       w_is_letter;
  logic       w_sweep_last;

  text_cursor u_cursor (
    .clk        (clk),
    .reset      (reset),
    .i_advance  (w_advance),
    .i_home     (w_home),
    .o_cursor_x (w_cursor_x),
    .o_cursor_y (w_cursor_y)
  );

  assign w_is_letter  = (r_code >= CODE_A) && (r_code <= CODE_Z);
  assign w_sweep_last = (r_sweep_x == 9'(SCREEN_W - 1)) && (r_sweep_y == 8'(SCREEN_H - 1));
  assign w_accept     = char_valid && w_char_ready;

  // Pixel outputs fall back to the last plotted values so they stay stable when idle.
  always_comb begin
    w_next_state = r_state;
    w_char_ready = 1'b0;
    w_plot       = 1'b0;
    w_done       = 1'b0;
    w_advance    = 1'b0;
    w_home       = 1'b0;
    w_rom_index  = 4'd0;
    w_x          = r_x;
    w_y          = r_y;
    w_colour     = r_colour;
    case (r_state)
      ST_IDLE: begin
        w_char_ready = !clear_req && !reset;
        if (clear_req) begin
          w_next_state = ST_CLEAR;
        end else if (char_valid) begin
          w_next_state = ST_DRAW;
        end
      end
      ST_DRAW: begin
        w_plot      = 1'b1;
        w_rom_index = r_idx;
        w_x         = 8'(w_cursor_x + {7'd0, idx_col(r_idx)});
        w_y         = 7'(w_cursor_y + {6'd0, idx_row(r_idx)});
        w_colour    = (glyph_bit && w_is_letter) ? FG : BG;
        if (r_idx == IDX_LAST) begin
          w_next_state = ST_FINISH;
        end
      end
      ST_CLEAR: begin
        w_plot   = 1'b1;
        w_x      = 8'(r_sweep_x);
        w_y      = 7'(r_sweep_y);
        w_colour = BG;
        if (w_sweep_last) begin
          w_next_state = ST_FINISH;
        end
      end
      ST_FINISH: begin
        w_done       = 1'b1;
        w_home       = r_clear_op;
        w_advance    = !r_clear_op;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= 4'd0;
      r_code     <= 5'd0;
      r_sweep_x  <= 9'd0;
      r_sweep_y  <= 8'd0;
      r_clear_op <= 1'b0;
      r_x        <= 8'd0;
      r_y        <= 7'd0;
      r_colour   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      if (w_plot) begin
        r_x      <= w_x;
        r_y      <= w_y;
        r_colour <= w_colour;
      end
      case (r_state)
        ST_IDLE: begin
          if (clear_req) begin
            r_clear_op <= 1'b1;
            r_sweep_x  <= 9'd0;
            r_sweep_y  <= 8'd0;
          end else if (w_accept) begin
            r_clear_op <= 1'b0;
            r_code     <= char_code;
            r_idx      <= 4'd0;
          end
        end
        ST_DRAW: r_idx <= r_idx + 4'd1;
        // x is the inner sweep counter.
        ST_CLEAR: begin
          if (r_sweep_x == 9'(SCREEN_W - 1)) begin
            r_sweep_x <= 9'd0;
            r_sweep_y <= r_sweep_y + 8'd1;
          end else begin
            r_sweep_x <= r_sweep_x + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign char_ready = w_char_ready;
  assign rom_char   = r_code;
  assign rom_index  = w_rom_index;
  assign x          = w_x;
  assign y          = w_y;
  assign colour     = w_colour;
  assign plot       = w_plot;
  assign busy       = (r_state != ST_IDLE);
  assign done       = w_done;

endmodule

// File: tb/tb_text_draw_controller.sv
// Self-checking bench for text_draw_controller: random glyph streams against a
// cell-position/ROM reference model, clear sweep, blank codes and resets.
module tb_text_draw_controller;

  logic       clk;
  logic       reset;
  logic       char_valid;
  logic [4:0] char_code;
  logic       char_ready;
  logic       clear_req;
  logic [4:0] rom_char;
  logic [3:0] rom_index;
  logic       glyph_bit;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  logic       forceOne;
  int         checks;
  int         failures;
  int         glyphCount;
  int         maxPlotX;
  int         maxPlotY;

  text_draw_controller dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_ready (char_ready),
    .clear_req  (clear_req),
    .rom_char   (rom_char),
    .rom_index  (rom_index),
    .glyph_bit  (glyph_bit),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference glyph ROM: 'A' has only pixels 5 and 6 clear, others are a fixed hash.
  function automatic logic romBit(input logic [4:0] code, input logic [3:0] idx);
    logic [15:0] pattern;
    if (code == 5'd1) pattern = 16'hFF9F;
    else pattern = ({11'd0, code} * 16'd40503) ^ 16'h5A5A;
    return pattern[idx];
  endfunction

  assign glyph_bit = forceOne | romBit(rom_char, rom_index);

  function automatic logic [2:0] expColour(input logic [4:0] code, input int k);
    if (code >= 5'd1 && code <= 5'd26 && (forceOne || romBit(code, 4'(k)))) return 3'b111;
    return 3'b000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Sends one code and checks all 16 plots, the done pulse and the ready window.
  // Cell position comes from the number of glyphs since the cursor was homed.
  task automatic applyStimulus(input logic [4:0] code, input string tag);
    int budget;
    int lowCount;
    int ex;
    int ey;
    ex = 2 + 5 * (glyphCount % 31);
    ey = 2 + 6 * ((glyphCount / 31) % 20);
    budget = 0;
    while (char_ready !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    checkOutput({tag, "_ready_wait"}, {31'd0, char_ready}, 32'd1);
    if (char_ready !== 1'b1) return;
    char_valid = 1'b1;
    char_code  = code;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    char_code  = 5'($urandom);
    lowCount   = 0;
    for (int k = 0; k < 16; k++) begin
      checkOutput({tag, "_pixel"},
                  {4'd0, plot, x, y, colour, rom_char, rom_index},
                  {4'd0, 1'b1, 8'(ex + k % 4), 7'(ey + k / 4), expColour(code, k), code, 4'(k)});
      if (plot === 1'b1 && int'(x) > maxPlotX) maxPlotX = int'(x);
      if (plot === 1'b1 && int'(y) > maxPlotY) maxPlotY = int'(y);
      if (char_ready === 1'b0) lowCount++;
      @(negedge clk);
    end
    checkOutput({tag, "_done"}, {29'd0, done, plot, busy}, {29'd0, 3'b101});
    if (char_ready === 1'b0) lowCount++;
    @(negedge clk);
    checkOutput({tag, "_idle"}, {25'd0, char_ready, done, busy, rom_index}, {25'd0, 3'b100, 4'd0});
    checkOutput({tag, "_ready_low"}, lowCount, 32'd17);
    glyphCount++;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int plotCount;
    int orderErrs;
    int colourErrs;
    int readyHigh;
    int doneSeen;
    logic [7:0] lastX;
    logic [6:0] lastY;

    checks     = 0;
    failures   = 0;
    glyphCount = 0;
    maxPlotX   = 0;
    maxPlotY   = 0;
    forceOne   = 1'b0;
    reset      = 1'b1;
    char_valid = 1'b0;
    char_code  = 5'd0;
    clear_req  = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {11'd0, plot, busy, done, char_ready, x, y, colour}, 32'd0);
    checkOutput("reset_rom", {23'd0, rom_char, rom_index}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", {30'd0, char_ready, busy}, {30'd0, 2'b10});

    $display("[TB] glyph A at origin");
    applyStimulus(5'd1, "glyph_A");

    $display("[TB] 32 random codes with line wrap");
    for (int i = 0; i < 32; i++) applyStimulus(5'($urandom_range(0, 31)), "seq32");
    checkOutput("line_wrap_count", glyphCount, 32'd33);

    $display("[TB] clear with simultaneous char_valid");
    clear_req  = 1'b1;
    char_valid = 1'b1;
    char_code  = 5'd5;
    #1;
    checkOutput("clear_priority_ready", {31'd0, char_ready}, 32'd0);
    @(posedge clk);
    plotCount = 0; orderErrs = 0; colourErrs = 0; readyHigh = 0; doneSeen = 0;
    lastX = 8'd0; lastY = 7'd0;
    for (int c = 0; c < 19300; c++) begin
      @(negedge clk);
      if (c == 0) clear_req = 1'b0;
      if (char_ready !== 1'b0) readyHigh++;
      if (plot === 1'b1) begin
        if (int'(x) != plotCount % 160 || int'(y) != plotCount / 160) orderErrs++;
        if (colour !== 3'b000) colourErrs++;
        lastX = x;
        lastY = y;
        plotCount++;
      end
      if (done === 1'b1) begin
        doneSeen = 1;
        char_valid = 1'b0;
        break;
      end
    end
    checkOutput("clear_done_seen", doneSeen, 32'd1);
    checkOutput("clear_plots", plotCount, 32'd19200);
    checkOutput("clear_order", orderErrs, 32'd0);
    checkOutput("clear_colour", colourErrs, 32'd0);
    checkOutput("clear_last", {17'd0, lastX, lastY}, {17'd0, 8'd159, 7'd119});
    checkOutput("clear_ready_low", readyHigh, 32'd0);
    char_valid = 1'b0;
    @(negedge clk);
    checkOutput("clear_idle", {30'd0, busy, char_ready}, {30'd0, 2'b01});
    glyphCount = 0;
    applyStimulus(5'd3, "after_clear");

    $display("[TB] blank codes with glyph_bit forced high");
    forceOne = 1'b1;
    applyStimulus(5'd0, "blank_space");
    applyStimulus(5'd30, "blank_30");
    forceOne = 1'b0;
    applyStimulus(5'd2, "after_blank");

    $display("[TB] reset on 8th draw cycle");
    char_valid = 1'b1;
    char_code  = 5'd1;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("mid_draw_index", {26'd0, plot, busy, rom_index}, {26'd0, 2'b11, 4'd7});
    #2 reset = 1'b1;
    #1 checkOutput("reset_draw_drop", {28'd0, plot, busy, done, char_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    doneSeen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) doneSeen++;
    end
    checkOutput("reset_draw_no_done", doneSeen, 32'd0);
    glyphCount = 0;
    applyStimulus(5'd1, "after_draw_reset");

    $display("[TB] reset mid clear");
    clear_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_req = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("mid_clear_plot", {30'd0, plot, busy}, {30'd0, 2'b11});
    #2 reset = 1'b1;
    #1 checkOutput("reset_clear_drop", {28'd0, plot, busy, done, char_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    doneSeen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) doneSeen++;
    end
    checkOutput("reset_clear_no_done", doneSeen, 32'd0);
    glyphCount = 0;
    applyStimulus(5'd26, "after_clear_reset");

    $display("[TB] fill screen to vertical wrap");
    maxPlotX = 0;
    maxPlotY = 0;
    while (glyphCount < 620) applyStimulus(5'($urandom_range(0, 31)), "fill");
    checkOutput("fill_last_row", {31'd0, maxPlotY == 119}, 32'd1);
    applyStimulus(5'($urandom_range(1, 26)), "vertical_wrap");
    checkOutput("x_bound", {31'd0, maxPlotX <= 159}, 32'd1);
    checkOutput("y_bound", {31'd0, maxPlotY <= 119}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
